// File: rtl/store_block_pkg.sv
// Shared types for the store read-modify-write block: store types, FSM states, alignment masks.
package store_pkg;

  typedef enum logic [2:0] {
    ST_NONE = 3'd0,
    ST_SD   = 3'd1,
    ST_SW   = 3'd2,
    ST_SH   = 3'd3,
    ST_SB   = 3'd4
  } store_type_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WRITE,
    DONE,
    ERR
  } state_e;

  localparam logic [2:0] ALIGN_SD = 3'b111;
  localparam logic [2:0] ALIGN_SW = 3'b011;
  localparam logic [2:0] ALIGN_SH = 3'b001;
  localparam logic [2:0] ALIGN_SB = 3'b000;

  // High for an invalid type or an offset that breaks natural alignment.
  function automatic logic store_bad(input logic [2:0] t, input logic [2:0] off);
    case (t)
      ST_SD:   store_bad = |(off & ALIGN_SD);
      ST_SW:   store_bad = |(off & ALIGN_SW);
      ST_SH:   store_bad = |(off & ALIGN_SH);
      ST_SB:   store_bad = |(off & ALIGN_SB);
      default: store_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_block_if.sv
// Control handshake and data-memory bus of store_block.
// mem_be exists only when STORE_BYTE_MASK_EN is defined.
interface store_block_if;
  import store_pkg::*;

  logic        start;
  logic [2:0]  StoreTYPE;
  logic [63:0] Addr;
  logic [63:0] RegData;
  logic [63:0] mem_addr;
  logic        mem_re;
  logic [63:0] mem_rdata;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        store_err;
`ifdef STORE_BYTE_MASK_EN
  logic [7:0]  mem_be;
`endif

  modport slave (
`ifdef STORE_BYTE_MASK_EN
    output mem_be,
`endif
    input  start, StoreTYPE, Addr, RegData, mem_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata, busy, done, store_err
  );

  modport master (
`ifdef STORE_BYTE_MASK_EN
    input  mem_be,
`endif
    output start, StoreTYPE, Addr, RegData, mem_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata, busy, done, store_err
  );

endinterface

// File: rtl/store_merge.sv
// Combinational lane merge: drops the low bytes of i_new into the addressed lanes of i_old.
module store_merge
  import store_pkg::*;
(
  input  store_type_e i_type,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_old,
  input  logic [63:0] i_new,
  output logic [63:0] o_merged,
  output logic [7:0]  o_mask
);

  logic [63:0] w_bits;
  logic [63:0] w_shifted;

  always_comb begin
    case (i_type)
      ST_SD:   o_mask = 8'hFF;
      ST_SW:   o_mask = 8'h0F << i_off;
      ST_SH:   o_mask = 8'h03 << i_off;
      ST_SB:   o_mask = 8'h01 << i_off;
      default: o_mask = 8'h00;
    endcase
  end

  always_comb begin
    w_bits = '0;
    for (int i = 0; i < 8; i++) begin
      w_bits[8*i +: 8] = {8{o_mask[i]}};
    end
  end

  // Offsets are naturally aligned here, so a byte shift lands the data on its lanes.
  assign w_shifted = i_new << {i_off, 3'b000};
  assign o_merged  = (i_old & ~w_bits) | (w_shifted & w_bits);

endmodule

// File: rtl/store_block.sv
// SD/SW/SH/SB store sequencer doing read-modify-write on a 64-bit data memory.
// Define STORE_BYTE_MASK_EN to drive mem_be and skip the read phase.
module store_block
  import store_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input logic         clk,
  input logic         reset,
  store_block_if.slave bus
);

  // state   | meaning
  // IDLE    | waiting for start
  // RD_REQ  | read strobe for the target doubleword
  // RD_WAIT | counting down read latency, capture old data at zero
  // WRITE   | one-cycle write of the merged doubleword
  // DONE    | completion pulse
  // ERR     | completion pulse with store_err

  localparam logic [2:0] LAT_M1 = 3'(MEM_RD_LAT - 1);

  state_e      r_state;
  logic [2:0]  r_type_q;
  logic [2:0]  r_cnt;
  logic [63:0] r_addr_q;
  logic [63:0] r_data_q;
  logic [63:0] r_old_q;
  logic        r_mem_re;
  logic        r_mem_we;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [63:0] w_merged;
  logic [7:0]  w_mask;
  logic        w_bad;
  logic        w_direct;

  assign w_bad = store_bad(bus.StoreTYPE, bus.Addr[2:0]);

`ifdef STORE_BYTE_MASK_EN
  assign w_direct = 1'b1;
`else
  assign w_direct = (bus.StoreTYPE == ST_SD);
`endif

  store_merge u_merge (
    .i_type   (store_type_e'(r_type_q)),
    .i_off    (r_addr_q[2:0]),
    .i_old    (r_old_q),
    .i_new    (r_data_q),
    .o_merged (w_merged),
    .o_mask   (w_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_type_q <= '0;
      r_cnt    <= '0;
      r_addr_q <= '0;
      r_data_q <= '0;
      r_old_q  <= '0;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_type_q <= bus.StoreTYPE;
            r_addr_q <= bus.Addr;
            r_data_q <= bus.RegData;
            r_busy   <= 1'b1;
            if (w_bad) begin
              r_state <= ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (w_direct) begin
              r_state  <= WRITE;
              r_mem_we <= 1'b1;
            end else begin
              r_state  <= RD_REQ;
              r_mem_re <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          r_cnt   <= LAT_M1;
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_old_q  <= bus.mem_rdata;
            r_state  <= WRITE;
            r_mem_we <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        WRITE: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE, ERR: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Never strobe a write that touches no lanes.
  assign bus.mem_we    = r_mem_we & (|w_mask);
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_addr  = {r_addr_q[63:3], 3'b000};
  assign bus.mem_wdata = w_merged;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.store_err = r_err;
`ifdef STORE_BYTE_MASK_EN
  assign bus.mem_be    = w_mask;
`endif

endmodule

// File: tb/tb_store_block.sv
// Bench for store_block: byte-lane reference model checked every cycle plus directed literal checks.
module tb_store_block;
  import store_pkg::*;

  localparam int LAT = 3;
`ifdef STORE_BYTE_MASK_EN
  localparam bit MASK_MODE = 1'b1;
`else
  localparam bit MASK_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_block_if bus ();

  store_block #(.MEM_RD_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Memory returns data exactly LAT cycles after the strobe, garbage otherwise.
  logic [63:0] rd_val = '0;
  int rd_due = -100;
  always @(posedge clk) if (bus.mem_re) rd_due <= cyc + LAT;
  assign bus.mem_rdata = (cyc == rd_due) ? rd_val : 64'hBAD0_BAD0_BAD0_BAD0;

  bit          m_act = 1'b0;
  int          m_s = 0;
  int          m_l = 0;
  bit          m_err, m_rd;
  logic [63:0] m_wdata, m_addr;
  logic [7:0]  m_be;

  logic [63:0] ob_wdata = '0;
  int          ob_done_cyc = 0;
  int          ob_we_cnt = 0;
  int          ob_re_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, a, e);
    end
  endtask

  function automatic int size_of(input logic [2:0] t);
    case (t)
      3'd1: return 8;
      3'd2: return 4;
      3'd3: return 2;
      3'd4: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model(input logic [2:0] t, input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] old);
    int sz = size_of(t);
    int k  = int'(a[2:0]);
    m_err  = (sz == 0) || ((k % sz) != 0);
    m_rd   = !m_err && !MASK_MODE && (sz != 8);
    m_l    = m_err ? 1 : (m_rd ? LAT + 3 : 2);
    m_addr = {a[63:3], 3'b000};
    m_be   = '0;
    for (int b = 0; b < 8; b++) begin
      if (!m_err && b >= k && b < k + sz) begin
        m_be[b] = 1'b1;
        m_wdata[8*b +: 8] = d[8*(b-k) +: 8];
      end else begin
        m_wdata[8*b +: 8] = MASK_MODE ? 8'h00 : old[8*b +: 8];
      end
    end
  endtask

  always @(negedge clk) begin
    bit e_re, e_we, e_done, e_busy;
    if (!reset) begin
      e_busy = m_act && cyc > m_s && cyc <= m_s + m_l;
      e_done = m_act && cyc == m_s + m_l;
      e_we   = m_act && !m_err && cyc == m_s + m_l - 1;
      e_re   = m_act && m_rd && cyc == m_s + 1;
      chk("busy", 64'(bus.busy), 64'(e_busy));
      chk("done", 64'(bus.done), 64'(e_done));
      chk("store_err", 64'(bus.store_err), 64'(e_done && m_err));
      chk("mem_we", 64'(bus.mem_we), 64'(e_we));
      chk("mem_re", 64'(bus.mem_re), 64'(e_re));
      if (e_we) begin
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("mem_addr_wr", bus.mem_addr, m_addr);
`ifdef STORE_BYTE_MASK_EN
        chk("mem_be", 64'(bus.mem_be), 64'(m_be));
`endif
      end
      if (e_re) chk("mem_addr_rd", bus.mem_addr, m_addr);
    end
    if (bus.mem_we) begin
      ob_wdata = bus.mem_wdata;
      ob_we_cnt++;
    end
    if (bus.mem_re) ob_re_cnt++;
    if (bus.done) ob_done_cyc = cyc;
  end

  task automatic issue(input logic [2:0] t, input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] old);
    @(negedge clk);
    #1;
    rd_val = old;
    model(t, a, d, old);
    m_s = cyc;
    m_act = 1'b1;
    bus.start = 1'b1;
    bus.StoreTYPE = t;
    bus.Addr = a;
    bus.RegData = d;
    @(negedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc < m_s + m_l) @(negedge clk);
    #2;
  endtask

  task automatic pulse_stray(input int at_cyc);
    while (cyc < at_cyc) @(negedge clk);
    #1;
    bus.start = 1'b1;
    bus.StoreTYPE = 3'd1;
    bus.Addr = 64'h800;
    bus.RegData = 64'hCAFE_CAFE_CAFE_CAFE;
    @(negedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, re0;
    bus.start = 1'b0;
    bus.StoreTYPE = '0;
    bus.Addr = '0;
    bus.RegData = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_addr", bus.mem_addr, 64'd0);
    chk("rst_wdata", bus.mem_wdata, 64'd0);
    #1 reset = 1'b0;

    // SD: direct write, no read
    re0 = ob_re_cnt;
    issue(3'd1, 64'h100, 64'h1122_3344_5566_7788, 64'h0);
    wait_done();
    chk("sd_wdata", ob_wdata, 64'h1122_3344_5566_7788);
    chk("sd_lat", 64'(ob_done_cyc - m_s), 64'd2);
    chk("sd_no_re", 64'(ob_re_cnt - re0), 64'd0);

    // SB with junk upper RegData bits, back-to-back with the SD
    issue(3'd4, 64'h105, 64'h7777_7777_7777_77AB, 64'hFFEE_DDCC_BBAA_9988);
    wait_done();
    chk("sb_wdata", ob_wdata, MASK_MODE ? 64'h0000_AB00_0000_0000 : 64'hFFEE_ABCC_BBAA_9988);
    chk("sb_lat", 64'(ob_done_cyc - m_s), MASK_MODE ? 64'd2 : 64'd6);

    issue(3'd2, 64'h204, 64'hDEAD_BEEF, 64'h0);
    wait_done();
    chk("sw_upper", ob_wdata, 64'hDEAD_BEEF_0000_0000);

    issue(3'd3, 64'h306, 64'h1234, 64'h0011_2233_4455_6677);
    wait_done();
    chk("sh_top", ob_wdata, MASK_MODE ? 64'h1234_0000_0000_0000 : 64'h1234_2233_4455_6677);
    chk("sh_top_lat", 64'(ob_done_cyc - m_s), MASK_MODE ? 64'd2 : 64'd6);

    // Error cases: misaligned and invalid types never touch memory
    we0 = ob_we_cnt;
    re0 = ob_re_cnt;
    issue(3'd3, 64'h301, 64'h55, 64'h0);
    wait_done();
    chk("sh_mis_lat", 64'(ob_done_cyc - m_s), 64'd1);
    issue(3'd6, 64'h100, 64'h55, 64'h0);
    wait_done();
    issue(3'd2, 64'h202, 64'h55, 64'h0);
    wait_done();
    issue(3'd1, 64'h104, 64'h55, 64'h0);
    wait_done();
    issue(3'd0, 64'h100, 64'h55, 64'h0);
    wait_done();
    issue(3'd7, 64'h100, 64'h55, 64'h0);
    wait_done();
    chk("err_no_we", 64'(ob_we_cnt - we0), 64'd0);
    chk("err_no_re", 64'(ob_re_cnt - re0), 64'd0);

    // Reset in mid-operation
    issue(3'd4, 64'h105, 64'hAB, 64'h1111_1111_1111_1111);
    while (cyc < m_s + (MASK_MODE ? 1 : 3)) @(negedge clk);
    #1;
    reset = 1'b1;
    m_act = 1'b0;
    we0 = ob_we_cnt;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_we", 64'(ob_we_cnt - we0), 64'd0);

    issue(3'd3, 64'h302, 64'hBEEF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done();
    chk("sh_after_rst", ob_wdata, MASK_MODE ? 64'h0000_0000_BEEF_0000 : 64'hFFFF_FFFF_BEEF_FFFF);

    // Stray starts while busy and in DONE are ignored
    we0 = ob_we_cnt;
    issue(3'd4, 64'h103, 64'h5A, 64'h0102_0304_0506_0708);
    pulse_stray(m_s + 1);
    pulse_stray(m_s + m_l);
    @(negedge clk);
    #1;
    m_act = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("stray_one_we", 64'(ob_we_cnt - we0), 64'd1);
    chk("stray_wdata", ob_wdata, MASK_MODE ? 64'h0000_0000_5A00_0000 : 64'h0102_0304_5A06_0708);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_block.md
Name: store_block

Overview:
- Store-side counterpart of the load extender in the 64-bit RISC-V datapath.
- Executes SD/SW/SH/SB as a sequenced read-modify-write against the 64-bit doubleword data memory.
- Places register data into the addressed byte lane(s), preserves the untouched bytes, and handshakes with the main control FSM through start/done.

Parameters:
- MEM_RD_LAT, 1: data-memory read latency in cycles from mem_re to valid mem_rdata (range 1..7).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request from control; sampled only in IDLE.
- StoreTYPE  input  3  1=SD, 2=SW, 3=SH, 4=SB; 0,5,6,7 are invalid.
- Addr  input  64  byte address of the store.
- RegData  input  64  rs2 value; only the low 8/16/32/64 bits are used.
- mem_addr  output  64  doubleword address, {Addr_q[63:3],3'b0}.
- mem_re  output  1  memory read strobe.
- mem_rdata  input  64  memory read data.
- mem_we  output  1  memory write strobe.
- mem_wdata  output  64  merged doubleword.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- store_err  output  1  one-cycle pulse together with done on a misaligned access or invalid type.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state to IDLE;
  - mem_re, mem_we, done, store_err, busy to 0;
  - mem_addr, mem_wdata, and all latched registers to 0.
- Reset mid-operation aborts immediately. No write is issued after a reset edge.
- Input latching: in IDLE, start=1 latches StoreTYPE, Addr and RegData into _q registers. start while busy is ignored, not queued.
- Alignment rules; a violation means error and no memory access:
  - SD: Addr[2:0]==0.
  - SW: Addr[1:0]==0.
  - SH: Addr[0]==0.
  - SB: always aligned.
- States:
  - IDLE: on start, go to ERR if the type is invalid or misaligned; go to WRITE if SD; otherwise go to RD_REQ.
  - RD_REQ: mem_re=1 for one cycle; load the wait counter with MEM_RD_LAT-1; go to RD_WAIT.
  - RD_WAIT: decrement the counter. When the counter is 0, capture mem_rdata into old_q and go to WRITE.
  - WRITE: mem_we=1 for exactly one cycle, with mem_wdata valid in the same cycle; go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
  - ERR: done=1 and store_err=1 for one cycle; go to IDLE.
- Merge, with byte offset k = Addr_q[2:0]:
  - SD: mem_wdata = RegData_q.
  - SW: bits [32*k[2]+:32] = RegData_q[31:0].
  - SH: bits [16*k[2:1]+:16] = RegData_q[15:0].
  - SB: bits [8*k+:8] = RegData_q[7:0].
  - All other bits come from old_q.
- Latency from the cycle start is sampled to the done cycle:
  - SD: 2 cycles (WRITE, DONE).
  - Partial stores: MEM_RD_LAT+3 cycles.
  - Error: 1 cycle.
- Back-to-back: a new start is accepted in the cycle after done, i.e. when the FSM is back in IDLE.
- mem_addr is held stable from RD_REQ through WRITE.

Optional Feature:
- Macro: STORE_BYTE_MASK_EN.
- When defined:
  - Add output mem_be[7:0], the byte-enable mask for the stored lanes: SD 0xFF, SW 0x0F<<k, SH 0x03<<k, SB 0x01<<k.
  - RD_REQ and RD_WAIT are bypassed for all types, so every valid store completes in 2 cycles.
  - Bytes outside the mask in mem_wdata are 0.
- When undefined:
  - No mem_be port exists.
  - The read-modify-write path described above is used.

Decomposition:
- Package store_pkg holds:
  - the typedef enum for StoreTYPE (ST_SD=1, ST_SW=2, ST_SH=3, ST_SB=4);
  - the FSM state enum (IDLE, RD_REQ, RD_WAIT, WRITE, DONE, ERR);
  - the alignment-mask constants.
- One natural sub-module: store_merge, purely combinational. Inputs are type, offset, old doubleword and new data. Outputs are the merged doubleword and the byte mask. It is reused by the FSM and the optional mask path.

Test Plan:
- SD: Addr=0x100, RegData=0x1122334455667788 -> no mem_re; mem_we exactly one cycle with mem_wdata=0x1122334455667788 and mem_addr=0x100; done 2 cycles after start.
- SB: Addr=0x105, RegData=0xAB, mem_rdata=0xFFEEDDCCBBAA9988, MEM_RD_LAT=1 -> mem_wdata=0xFFEEABCCBBAA9988; done at cycle 4.
- SW upper: Addr=0x204, RegData=0xDEADBEEF, mem_rdata=0 -> mem_wdata=0xDEADBEEF00000000.
- Misaligned SH: Addr=0x301 -> done=1 and store_err=1 one cycle after start; mem_re and mem_we never asserted. StoreTYPE=6 -> same response.
- Reset asserted during RD_WAIT with MEM_RD_LAT=3 -> next cycle IDLE, busy=0; mem_we never pulses. A subsequent SH at Addr=0x302 completes normally.
- start pulsed while busy -> ignored; exactly one mem_we per accepted request. With STORE_BYTE_MASK_EN, SH at Addr=0x306 -> mem_be=0xC0; done 2 cycles after start.
